// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: per-cycle write-enable/clear for the PC and the
// four pipeline registers, plus data-memory handshake, HALT hold and stall counter.
module hazard_ctrl #(
  parameter logic [3:0] LOAD_OP  = 4'b1000,
  parameter logic [3:0] STORE_OP = 4'b1001,
  parameter logic [3:0] HLT_OP   = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_rs,
  input  logic [3:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [3:0]  ex_op,
  input  logic [3:0]  ex_rd,
  input  logic        ex_branch,
  input  logic [3:0]  mem_op,
  input  logic        dmem_ack,
  input  logic        imem_ack,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        id_ex_we,
  output logic        ex_mem_we,
  output logic        mem_wb_we,
  output logic        if_id_clr,
  output logic        id_ex_clr,
  output logic        dmem_req,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic mem_access;
  logic load_use;

  // dmem handshake: dmem_req stays high for every cycle a load/store sits in
  // EX/MEM; the access completes on the first cycle dmem_ack is seen with req high.
  // dmem_ack with no request is ignored.
  assign mem_access = (mem_op == LOAD_OP) || (mem_op == STORE_OP);

  // rd=0 keeps the all-zero bubble in ID/EX from ever looking like a load hazard
  assign load_use = (ex_op == LOAD_OP) && (ex_rd != 4'd0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    pc_we      = 1'b0;
    if_id_we   = 1'b0;
    id_ex_we   = 1'b0;
    ex_mem_we  = 1'b0;
    mem_wb_we  = 1'b0;
    if_id_clr  = 1'b0;
    id_ex_clr  = 1'b0;
    dmem_req   = 1'b0;
    state_next = state;

    if (rst) begin
      if_id_clr  = 1'b1;
      id_ex_clr  = 1'b1;
      state_next = RUN;
    end else begin
      case (state)
        HALT: begin
          state_next = HALT;
        end
        default: begin
          dmem_req   = mem_access;
          state_next = RUN;
          if (mem_access && !dmem_ack) begin
            state_next = MEM_WAIT;
          end else if (mem_op == HLT_OP) begin
            state_next = HALT;
          end else if (ex_branch) begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
            if_id_clr = 1'b1;
            id_ex_clr = 1'b1;
          end else if (load_use) begin
            // hold PC and IF/ID, inject a bubble into ID/EX, let the load move on
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
            id_ex_clr = 1'b1;
          end else if (!imem_ack) begin
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
            if_id_clr = 1'b1;
          end else begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= (state_next == HALT);
    end
  end

  // HALT cycles are not counted even though pc_we is low there
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if ((state != HALT) && !pc_we && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, hand-written multi-cycle sequences and a
// randomized phase, all checked against an abstract model of the pipeline rules.
module tb_hazard_ctrl;

  localparam logic [3:0] LD  = 4'b1000;
  localparam logic [3:0] ST  = 4'b1001;
  localparam logic [3:0] HLT = 4'b1111;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_rs, id_rt, ex_op, ex_rd, mem_op;
  logic        id_uses_rt, ex_branch, dmem_ack, imem_ack;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        if_id_clr, id_ex_clr, dmem_req, halted;
  logic [15:0] stall_cnt;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // model state: halted, waiting on memory, stall count
  bit m_halt;
  bit m_wait;
  int m_cnt;

  logic [7:0] exp_q[$];

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_op(ex_op), .ex_rd(ex_rd), .ex_branch(ex_branch), .mem_op(mem_op),
    .dmem_ack(dmem_ack), .imem_ack(imem_ack), .pc_we(pc_we), .if_id_we(if_id_we),
    .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
    .if_id_clr(if_id_clr), .id_ex_clr(id_ex_clr), .dmem_req(dmem_req),
    .halted(halted), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_clr, id_ex_clr, dmem_req}
  function automatic logic [7:0] model_out();
    bit ma, lu;
    if (rst) return 8'b00000_11_0;
    if (m_halt) return 8'b00000_00_0;
    ma = (mem_op == LD) || (mem_op == ST);
    lu = (ex_op == LD) && (ex_rd != 0) &&
         ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    if (ma && !dmem_ack) return 8'b00000_00_1;
    if (mem_op == HLT)   return 8'b00000_00_0;
    if (ex_branch)       return {7'b11111_11, ma};
    if (lu)              return {7'b00111_01, ma};
    if (!imem_ack)       return {7'b01111_10, ma};
    return {7'b11111_00, ma};
  endfunction

  task automatic set_in(input logic [3:0] rs, input logic [3:0] rt, input logic urt,
                        input logic [3:0] eop, input logic [3:0] erd, input logic br,
                        input logic [3:0] mop, input logic dack, input logic iack);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_op = eop; ex_rd = erd;
    ex_branch = br; mem_op = mop; dmem_ack = dack; imem_ack = iack;
  endtask

  task automatic set_idle();
    set_in(4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  // one clock: check combinational outputs mid-cycle, advance model, check registers
  task automatic step(input logic [7:0] exp_o, input string nm);
    logic [7:0] got, e, m;
    bit ma;
    exp_q.push_back(exp_o);
    @(negedge clk);
    got = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_clr, id_ex_clr, dmem_req};
    e = exp_q.pop_front();
    chk({nm, " outs"}, {24'd0, got}, {24'd0, e});
    m = model_out();
    ma = (mem_op == LD) || (mem_op == ST);
    if (rst) begin
      m_halt = 0; m_wait = 0; m_cnt = 0;
    end else if (!m_halt) begin
      if (!m[7] && m_cnt < 65535) m_cnt++;
      m_wait = ma && !dmem_ack;
      m_halt = !m_wait && (mem_op == HLT);
    end
    @(posedge clk);
    #1;
    chk({nm, " halted"}, {31'd0, halted}, {31'd0, m_halt});
    chk({nm, " stall_cnt"}, {16'd0, stall_cnt}, m_cnt);
    chk({nm, " state"}, {30'd0, dbg_state}, m_halt ? 32'd2 : (m_wait ? 32'd1 : 32'd0));
  endtask

  task automatic run(input string nm);
    step(model_out(), nm);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    step(8'b00000_11_0, "reset");
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] rs, rt;
    logic       urt;
    logic [3:0] eop, erd;
    logic       br;
    logic [3:0] mop;
    logic       dack, iack;
    logic [7:0] exp_o;
  } vec_t;

  vec_t vt[14];

  initial begin
    rst = 1'b1;
    set_idle();
    m_halt = 0; m_wait = 0; m_cnt = 0;

    do_reset();
    chk("reset stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("reset halted", {31'd0, halted}, 32'd0);

    // vector table
    vt[0]  = '{4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 8'b11111_00_0};
    vt[1]  = '{4'd3, 4'd0, 1'b0, LD,   4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 8'b00111_01_0};
    vt[2]  = '{4'd1, 4'd5, 1'b1, LD,   4'd5, 1'b0, 4'd0, 1'b0, 1'b1, 8'b00111_01_0};
    vt[3]  = '{4'd1, 4'd5, 1'b0, LD,   4'd5, 1'b0, 4'd0, 1'b0, 1'b1, 8'b11111_00_0};
    vt[4]  = '{4'd0, 4'd0, 1'b1, LD,   4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 8'b11111_00_0};
    vt[5]  = '{4'd3, 4'd0, 1'b0, 4'd1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1, 8'b11111_00_0};
    vt[6]  = '{4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'b01111_10_0};
    vt[7]  = '{4'd3, 4'd0, 1'b0, LD,   4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 8'b11111_11_0};
    vt[8]  = '{4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, ST,   1'b1, 1'b1, 8'b11111_00_1};
    vt[9]  = '{4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, LD,   1'b0, 1'b1, 8'b00000_00_1};
    vt[10] = '{4'd3, 4'd0, 1'b0, LD,   4'd3, 1'b0, LD,   1'b1, 1'b1, 8'b00111_01_1};
    vt[11] = '{4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 8'b11111_00_0};
    vt[12] = '{4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, LD,   1'b0, 1'b1, 8'b00000_00_1};
    vt[13] = '{4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, LD,   1'b1, 1'b1, 8'b11111_11_1};
    for (int i = 0; i < 14; i++) begin
      set_in(vt[i].rs, vt[i].rt, vt[i].urt, vt[i].eop, vt[i].erd, vt[i].br,
             vt[i].mop, vt[i].dack, vt[i].iack);
      step(vt[i].exp_o, $sformatf("vec%0d", i));
    end

    // load-use: exactly one bubble, then the bubble clears the hazard
    do_reset();
    set_in(4'd3, 4'd0, 1'b0, LD, 4'd3, 1'b0, 4'd0, 1'b0, 1'b1);
    step(8'b00111_01_0, "lu stall");
    set_in(4'd3, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, LD, 1'b1, 1'b1);
    step(8'b11111_00_1, "lu after bubble");
    chk("lu stall_cnt", {16'd0, stall_cnt}, 32'd1);

    // memory wait: ack three cycles after the request
    do_reset();
    set_in(4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, LD, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(8'b00000_00_1, "mw freeze");
      chk("mw state", {30'd0, dbg_state}, 32'd1);
    end
    dmem_ack = 1'b1;
    step(8'b11111_00_1, "mw advance");
    chk("mw stall_cnt", {16'd0, stall_cnt}, 32'd3);
    chk("mw back to run", {30'd0, dbg_state}, 32'd0);
    mem_op = ST;
    step(8'b11111_00_1, "zero wait");
    chk("zero wait stall_cnt", {16'd0, stall_cnt}, 32'd3);

    // fetch wait for two cycles
    do_reset();
    imem_ack = 1'b0;
    step(8'b01111_10_0, "fetch wait 1");
    step(8'b01111_10_0, "fetch wait 2");
    chk("fetch stall_cnt", {16'd0, stall_cnt}, 32'd2);

    // halt and hold through arbitrary inputs, then leave only via reset
    do_reset();
    mem_op = HLT;
    step(8'b00000_00_0, "halt entry");
    chk("halt rises", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      set_in(4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
             1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      step(8'b00000_00_0, "halt hold");
    end
    chk("halt stall_cnt", {16'd0, stall_cnt}, 32'd1);
    do_reset();
    chk("halt cleared", {31'd0, halted}, 32'd0);
    chk("halt cnt cleared", {16'd0, stall_cnt}, 32'd0);

    // saturation, then reset while frozen in MEM_WAIT
    set_idle();
    imem_ack = 1'b0;
    for (int i = 0; i < 65540; i++) run("sat");
    chk("sat stall_cnt", {16'd0, stall_cnt}, 32'hFFFF);
    set_in(4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, LD, 1'b0, 1'b1);
    run("pre-rst wait 1");
    run("pre-rst wait 2");
    chk("pre-rst state", {30'd0, dbg_state}, 32'd1);
    rst = 1'b1;
    step(8'b00000_11_0, "rst in mem_wait");
    rst = 1'b0;
    chk("post-rst state", {30'd0, dbg_state}, 32'd0);
    chk("post-rst cnt", {16'd0, stall_cnt}, 32'd0);
    mem_op = 4'd0;
    step(8'b11111_00_0, "post-rst run");

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] mop;
      case ($urandom_range(0, 9))
        0, 1:    mop = LD;
        2:       mop = ST;
        3:       mop = ($urandom_range(0, 3) == 0) ? HLT : 4'd2;
        default: mop = 4'($urandom_range(0, 7));
      endcase
      rst = ($urandom_range(0, 24) == 0);
      set_in(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom),
             ($urandom_range(0, 1) == 0) ? LD : 4'($urandom_range(0, 7)),
             4'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), mop,
             1'($urandom), ($urandom_range(0, 3) != 0));
      run("random");
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage processor. Each cycle it computes the write-enable and clear inputs for the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves:
- load-use stalls;
- taken-branch flushes;
- instruction-fetch wait bubbles;
- multi-cycle data-memory stalls, via a req/ack handshake.

It also holds the processor in HALT and keeps a saturating stall counter.

## Interface
Parameters:
- LOAD_OP, 4'b1000, opcode of load word
- STORE_OP, 4'b1001, opcode of store word
- HLT_OP, 4'b1111, opcode of halt

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_rs  in  4  rs field of instruction in IF/ID
- id_rt  in  4  rt field of instruction in IF/ID
- id_uses_rt  in  1  IF/ID instruction reads rt
- ex_op  in  4  opcode held in ID/EX
- ex_rd  in  4  destination register held in ID/EX
- ex_branch  in  1  branch resolved taken in EX this cycle
- mem_op  in  4  opcode held in EX/MEM
- dmem_ack  in  1  data memory completes the access this cycle
- imem_ack  in  1  fetched instruction valid this cycle
- pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1 each  register captures D when 1 (drives WriteReg)
- if_id_clr, id_ex_clr  out  1 each  register loads zero (ORed with rst at the register's reset input)
- dmem_req  out  1  data memory access request
- halted  out  1  processor halted (registered)
- stall_cnt  out  16  cycles with pc_we=0 (registered, saturating)

## Operation
- FSM states: RUN, MEM_WAIT, HALT.
- Reset values: state=RUN, halted=0, stall_cnt=0.
- While rst=1: all *_we=0, both clr=1, dmem_req=0.
- Signal definitions:
  - mem_access = (mem_op==LOAD_OP) | (mem_op==STORE_OP).
  - load_use = (ex_op==LOAD_OP) & (ex_rd!=0) & ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
- Outputs are combinational (Mealy) in RUN/MEM_WAIT. They are resolved in this priority order:
  1. HALT state: all we=0, clr=0, dmem_req=0, halted=1. HALT is left only via rst.
  2. mem_access & !dmem_ack: dmem_req=1, all we=0, clr=0 (full freeze). Next state MEM_WAIT.
  3. mem_op==HLT_OP: all we=0, clr=0. Next state HALT.
  4. ex_branch: all we=1, if_id_clr=1, id_ex_clr=1. This flushes the two wrong-path instructions and loads the target PC. It overrides load_use and imem wait.
  5. load_use: pc_we=0, if_id_we=0, id_ex_clr=1 (bubble), ex_mem_we=1, mem_wb_we=1.
  6. !imem_ack: pc_we=0, if_id_clr=1 (bubble into IF/ID), remaining we=1.
  7. Otherwise: all we=1, clr=0.
- dmem_req equals mem_access in RUN and MEM_WAIT, independent of priority.
  - When mem_access & dmem_ack: the pipeline advances with the lower-priority rules (4–7) applied.
  - Next state is RUN.
- MEM_WAIT uses the same rules as RUN. It exists so that the state is visible to the counter and to debug.
- The bubble is an all-zero ID/EX with rd=0. This guarantees load_use never fires on it.
- stall_cnt increments when rst=0, state!=HALT and pc_we=0. It saturates at 16'hFFFF.

## Timing
- Load-use costs exactly 1 bubble. The next cycle the load is in EX/MEM, and the bubble in ID/EX clears the hazard.
- Data memory: ack N cycles after req first rises gives N frozen cycles.
  - Ack in the same cycle as the request gives 0 stall.
  - Back-to-back memory ops request again on the cycle after the advance.
- Taken branch: 2-instruction penalty. No stall cycle is counted.
- HALT entered the cycle after mem_op==HLT_OP is seen with no pending memory stall. halted rises the same edge.
- Reset mid-stall (any state): next cycle RUN, counter 0, no dmem_req.
- dmem_ack without mem_access is ignored.

## Test plan
- Load-use: ex_op=LOAD_OP, ex_rd=3, id_rs=3 -> exactly 1 cycle of pc_we=0, if_id_we=0, id_ex_clr=1, ex_mem_we=1; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- Memory wait: mem_op=LOAD_OP, dmem_ack rises 3 cycles after dmem_req -> 3 cycles all we=0, state MEM_WAIT, then advance; stall_cnt=3. Zero-wait ack -> no freeze.
- Branch vs load-use: ex_branch=1 with load_use true and imem_ack=0 -> all we=1, if_id_clr=1, id_ex_clr=1; stall_cnt unchanged.
- Fetch wait: imem_ack=0 for 2 cycles -> pc_we=0, if_id_clr=1 each cycle, downstream we=1.
- Halt: mem_op=HLT_OP -> that cycle all we=0; halted=1 next edge; stays through 10 cycles of arbitrary inputs; rst for 1 cycle -> halted=0, state RUN, stall_cnt=0.
- Saturation/reset mid-stall: preload via 65540 stalled cycles -> stall_cnt=16'hFFFF; assert rst during MEM_WAIT -> all we=0, clr=1 during rst, RUN after.
